setup_ctrl: RTL and testbench
=============================

// Module: setup_ctrl
// PURPOSE
//   Synchronous controller for the clock's time-setting path. Debounces the four raw buttons,
//   sequences display mode and setup field selection, and edits a working copy of the time.
//   Issues a one-cycle load strobe to the timekeeping counter on commit.
//   Sits between the button pins and the time counter. No logic runs on button edges.
// PARAMETERS
//   DEBOUNCE_CYC  50_000       consecutive stable cycles before a button level is accepted
//   REPEAT_DLY    25_000_000   cycles button[1] must be held before auto-repeat starts
//   REPEAT_PER    5_000_000    cycles between auto-repeat increments
//   TIMEOUT_CYC   500_000_000  idle cycles in setup before automatic abort
// PORTS
//   clock       in   1   system clock; all state on posedge
//   reset       in   1   asynchronous, active-low reset
//   button      in   [0:3]  raw buttons, active-high: [0] mode, [1] increment, [2] next field, [3] commit
//   data_ch     in   24  live time {hours[23:16], minutes[15:8], seconds[7:0]}, binary per byte
//   rezhim      out  2   display mode 0..2; 3 = setup
//   field_sel   out  2   0 none, 1 seconds, 2 minutes, 3 hours
//   setup_data  out  24  working time being edited, same layout as data_ch
//   setup_imp   out  1   one-cycle load strobe: timekeeper loads setup_data
// BEHAVIOUR
//   Reset (async, immediate): rezhim=0, field_sel=0, setup_data=0, setup_imp=0.
//     Debounce and timers clear. Reset during setup never produces setup_imp.
//   Input path: each button passes through a 2-FF synchronizer, then the debouncer.
//     The debounced level changes only after DEBOUNCE_CYC equal consecutive samples.
//     A debounced rising edge gives a one-cycle press pulse.
//     The FSM reacts in the cycle after the press pulse.
//   Mode press outside setup: rezhim advances 0->1->2->3.
//     On entry to 3: setup_data <= data_ch; field_sel <= 0; timeout counter clears.
//   Setup (rezhim==3), per-cycle priority when events coincide:
//     mode > commit > next field > increment > timeout.
//     mode press: abort. rezhim<=0, field_sel<=0, no strobe; setup_data holds.
//     commit press: if field_sel!=0, setup_imp=1 for exactly one cycle,
//       then rezhim<=0 and field_sel<=0 in the same cycle. If field_sel==0, the press is ignored.
//     next-field press: field_sel cycles 0->1->2->3->0.
//     increment (press or auto-repeat), only when field_sel!=0:
//       the selected byte increments; 59->0 for seconds/minutes, 23->0 for hours.
//       A byte already above its max loads 0. Other bytes never change, and there is no carry.
//     auto-repeat: with debounced button[1] held, the first repeat fires REPEAT_DLY cycles
//       after the press, then every REPEAT_PER cycles. Release stops it immediately.
//     timeout: any press clears the counter. TIMEOUT_CYC cycles with no press: abort as for mode.
//   Outside setup: setup_data holds its last value; increment, next-field and commit are ignored.
//   setup_imp is never high for two consecutive cycles.
//   Counter widths come from $clog2(param+1). Counters saturate and do not wrap.
// STRUCTURE
//   Package chasy_pkg:
//     rezhim encodings (REZHIM_SETUP=3); field_e enum {F_NONE, F_SEC, F_MIN, F_HOUR}
//     SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23; byte-slice index constants for the time word.
//   Sub-module button_debounce (parameter DEBOUNCE_CYC): synchronizer + debounce counter;
//     outputs level and press pulse. Four instances.
//   Top level: mode/field FSM, edit datapath, repeat and timeout counters.
// TESTING (sim params: DEBOUNCE_CYC=4, REPEAT_DLY=20, REPEAT_PER=5, TIMEOUT_CYC=200)
//   1. button[1] toggling every 2 cycles for 20 cycles, then held high -> exactly one press pulse.
//   2. Three mode presses with data_ch=24'h17_3B_3A -> rezhim=3, setup_data=24'h173B3A, field_sel=0.
//   3. Wrap: field 1, two increments -> seconds 3A->3B->00, minutes unchanged;
//      field 3, one increment -> hours 17->00.
//   4. Commit in field 2 -> setup_imp high exactly 1 cycle; rezhim=0, field_sel=0 next cycle.
//      Commit with field_sel=0 -> no strobe, stays in setup.
//   5. Hold increment for 40 debounced cycles -> 1 press + 4 repeats = 5 increments.
//      Mode and commit pressed in the same cycle -> abort, no strobe.
//   6. No press for 200 cycles in setup -> rezhim=0, no strobe.
//      reset low mid-setup -> all outputs 0 immediately.

Source files
------------

// File: rtl/chasy_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// chasy_pkg : shared encodings and helpers for the clock time-setting path
// Revision  : 1.0
// ============================================================================
package chasy_pkg;

    typedef enum logic [1:0] {
        REZHIM_0     = 2'd0,
        REZHIM_1     = 2'd1,
        REZHIM_2     = 2'd2,
        REZHIM_SETUP = 2'd3
    } rezhim_e;

    typedef enum logic [1:0] {
        F_NONE = 2'd0,
        F_SEC  = 2'd1,
        F_MIN  = 2'd2,
        F_HOUR = 2'd3
    } field_e;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    localparam int BYTE_W   = 8;
    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 8;
    localparam int HOUR_LSB = 16;

    localparam int BTN_MODE   = 0;
    localparam int BTN_INC    = 1;
    localparam int BTN_NEXT   = 2;
    localparam int BTN_COMMIT = 3;

    // Anything at or above the limit (including corrupt values) restarts at 0.
    function automatic logic [7:0] wrap_inc(input logic [7:0] val, input logic [7:0] max);
        return (val >= max) ? 8'd0 : val + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// button_debounce : 2-FF synchronizer plus stable-count debouncer, press pulse
// Revision        : 1.0
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYC = 50_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    // Counts consecutive samples that disagree with the accepted level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign level_o = level_q;
    assign press_o = level_q & ~level_prev_q;

endmodule
`default_nettype wire

// File: rtl/setup_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// setup_ctrl : display-mode / setup-field FSM and time edit path with load strobe
// Revision   : 1.0
// ============================================================================
module setup_ctrl
    import chasy_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 50_000,
    parameter int REPEAT_DLY   = 25_000_000,
    parameter int REPEAT_PER   = 5_000_000,
    parameter int TIMEOUT_CYC  = 500_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:3]  button,
    input  logic [23:0] data_ch,
    output logic [1:0]  rezhim,
    output logic [1:0]  field_sel,
    output logic [23:0] setup_data,
    output logic        setup_imp
);

    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

    logic [3:0] btn_level;
    logic [3:0] btn_press;

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_db (
            .clock   (clock),
            .reset   (reset),
            .raw_i   (button[gi]),
            .level_o (btn_level[gi]),
            .press_o (btn_press[gi])
        );
    end

    rezhim_e     rezhim_q, rezhim_d;
    field_e      field_q, field_d;
    logic [23:0] data_q, data_d;
    logic        imp_q, imp_d;

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;
    logic             rep_fire;
    logic             rep_hold;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             timeout_hit;
    logic             inc_evt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rezhim_q    <= REZHIM_0;
            field_q     <= F_NONE;
            data_q      <= '0;
            imp_q       <= 1'b0;
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            rezhim_q    <= rezhim_d;
            field_q     <= field_d;
            data_q      <= data_d;
            imp_q       <= imp_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Auto-repeat runs only while increment is the sole button held.
    assign rep_hold = btn_level[BTN_INC] & ~btn_level[BTN_MODE]
                    & ~btn_level[BTN_NEXT] & ~btn_level[BTN_COMMIT];

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (!rep_hold) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (btn_press[BTN_INC]) begin
            rep_cnt_d   = REP_W'(1);
            rep_armed_d = 1'b0;
        end else if ((!rep_armed_q && rep_cnt_q == REP_W'(REPEAT_DLY)) ||
                     ( rep_armed_q && rep_cnt_q == REP_W'(REPEAT_PER))) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = REP_W'(1);
            rep_armed_d = 1'b1;
        end else if (rep_cnt_q != REP_W'(REP_MAX)) begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
    end

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (rezhim_q != REZHIM_SETUP || (|btn_press)) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT_CYC)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign timeout_hit = (rezhim_q == REZHIM_SETUP) && (to_cnt_q == TO_W'(TIMEOUT_CYC));
    assign inc_evt     = btn_press[BTN_INC] | rep_fire;

    // Setup events resolve in priority order: mode, commit, next, increment, timeout.
    always_comb begin
        rezhim_d = rezhim_q;
        field_d  = field_q;
        data_d   = data_q;
        imp_d    = 1'b0;
        if (rezhim_q == REZHIM_SETUP) begin
            if (btn_press[BTN_MODE]) begin
                rezhim_d = REZHIM_0;
                field_d  = F_NONE;
            end else if (btn_press[BTN_COMMIT] && field_q != F_NONE) begin
                imp_d    = 1'b1;
                rezhim_d = REZHIM_0;
                field_d  = F_NONE;
            end else if (btn_press[BTN_NEXT]) begin
                field_d = field_e'(field_q + 2'd1);
            end else if (inc_evt) begin
                case (field_q)
                    F_SEC:   data_d[SEC_LSB  +: BYTE_W] = wrap_inc(data_q[SEC_LSB  +: BYTE_W], SEC_MAX);
                    F_MIN:   data_d[MIN_LSB  +: BYTE_W] = wrap_inc(data_q[MIN_LSB  +: BYTE_W], MIN_MAX);
                    F_HOUR:  data_d[HOUR_LSB +: BYTE_W] = wrap_inc(data_q[HOUR_LSB +: BYTE_W], HOUR_MAX);
                    default: data_d = data_q;
                endcase
            end else if (timeout_hit) begin
                rezhim_d = REZHIM_0;
                field_d  = F_NONE;
            end
        end else if (btn_press[BTN_MODE]) begin
            rezhim_d = rezhim_e'(rezhim_q + 2'd1);
            if (rezhim_q == REZHIM_2) begin
                data_d  = data_ch;
                field_d = F_NONE;
            end
        end
    end

    assign rezhim     = rezhim_q;
    assign field_sel  = field_q;
    assign setup_data = data_q;
    assign setup_imp  = imp_q;

endmodule
`default_nettype wire

// File: tb/tb_setup_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_setup_ctrl : directed self-checking bench for setup_ctrl
// Revision      : 1.0
// ============================================================================
module tb_setup_ctrl;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [0:3]  button  = 4'b0000;
    logic [23:0] data_ch = 24'h173B3A;
    logic [1:0]  rezhim;
    logic [1:0]  field_sel;
    logic [23:0] setup_data;
    logic        setup_imp;

    int n_chk         = 0;
    int n_fail        = 0;
    int imp_cnt       = 0;
    int imp_double    = 0;
    int rez_after_imp = -1;
    logic imp_prev    = 1'b0;

    setup_ctrl #(
        .DEBOUNCE_CYC (4),
        .REPEAT_DLY   (20),
        .REPEAT_PER   (5),
        .TIMEOUT_CYC  (200)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .button     (button),
        .data_ch    (data_ch),
        .rezhim     (rezhim),
        .field_sel  (field_sel),
        .setup_data (setup_data),
        .setup_imp  (setup_imp)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imp_prev) rez_after_imp = int'({rezhim, field_sel});
        if (imp_prev && setup_imp) imp_double++;
        if (setup_imp) imp_cnt++;
        imp_prev = setup_imp;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input int b, input int hold);
        button[b] = 1'b1;
        tick(hold);
        button[b] = 1'b0;
        tick(12);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int waited;

        tick(3);
        check("rst_rezhim", 32'(rezhim), 0);
        check("rst_field", 32'(field_sel), 0);
        check("rst_data", 32'(setup_data), 0);
        check("rst_imp", 32'(setup_imp), 0);
        reset = 1'b1;
        tick(2);

        press(0, 8);
        check("mode1", 32'(rezhim), 1);
        press(0, 8);
        check("mode2", 32'(rezhim), 2);
        press(0, 8);
        check("mode3", 32'(rezhim), 3);
        check("capture", 32'(setup_data), 32'h173B3A);
        check("entry_field", 32'(field_sel), 0);
        data_ch = 24'h000000;

        press(1, 8);
        check("inc_field0", 32'(setup_data), 32'h173B3A);
        press(2, 8);
        check("field1", 32'(field_sel), 1);

        for (int i = 0; i < 10; i++) begin
            button[1] = ~button[1];
            tick(2);
        end
        button[1] = 1'b1;
        tick(8);
        button[1] = 1'b0;
        tick(12);
        check("bounce_one_press", 32'(setup_data), 32'h173B3B);

        press(1, 8);
        check("sec_wrap", 32'(setup_data), 32'h173B00);
        press(2, 8);
        press(2, 8);
        check("field3", 32'(field_sel), 3);
        press(1, 8);
        check("hour_wrap", 32'(setup_data), 32'h003B00);
        press(2, 8);
        check("field_wrap", 32'(field_sel), 0);

        press(3, 8);
        check("commit_f0_stay", 32'(rezhim), 3);
        check("commit_f0_nostrobe", 32'(imp_cnt), 0);

        press(2, 8);
        press(2, 8);
        check("field2", 32'(field_sel), 2);
        press(3, 8);
        check("commit_strobe", 32'(imp_cnt), 1);
        check("commit_after", 32'(rez_after_imp), 0);
        check("commit_rezhim", 32'(rezhim), 0);
        check("commit_data_hold", 32'(setup_data), 32'h003B00);

        press(1, 8);
        press(2, 8);
        press(3, 8);
        check("idle_data", 32'(setup_data), 32'h003B00);
        check("idle_field", 32'(field_sel), 0);
        check("idle_nostrobe", 32'(imp_cnt), 1);

        data_ch = 24'h0A0B37;
        press(0, 8);
        press(0, 8);
        press(0, 8);
        check("capture2", 32'(setup_data), 32'h0A0B37);
        data_ch = 24'hFFFFFF;
        press(2, 8);
        press(1, 38);
        check("auto_repeat", 32'(setup_data), 32'h0A0B00);

        button[0] = 1'b1;
        button[3] = 1'b1;
        tick(8);
        button[0] = 1'b0;
        button[3] = 1'b0;
        tick(12);
        check("mode_commit_abort", 32'(rezhim), 0);
        check("mode_commit_nostrobe", 32'(imp_cnt), 1);
        check("abort_data_hold", 32'(setup_data), 32'h0A0B00);

        data_ch = 24'h010203;
        press(0, 8);
        press(0, 8);
        press(0, 8);
        tick(150);
        check("no_early_timeout", 32'(rezhim), 3);
        waited = 0;
        while (rezhim == 2'd3 && waited < 100) begin
            tick(1);
            waited++;
        end
        check("timeout_rezhim", 32'(rezhim), 0);
        check("timeout_latency", 32'(waited >= 30 && waited <= 46), 1);
        check("timeout_nostrobe", 32'(imp_cnt), 1);

        press(0, 8);
        press(0, 8);
        press(0, 8);
        press(2, 8);
        press(1, 8);
        check("pre_reset_data", 32'(setup_data), 32'h010204);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("areset_rezhim", 32'(rezhim), 0);
        check("areset_field", 32'(field_sel), 0);
        check("areset_data", 32'(setup_data), 0);
        check("areset_imp", 32'(setup_imp), 0);
        tick(3);
        check("areset_nostrobe", 32'(imp_cnt), 1);
        check("imp_never_double", 32'(imp_double), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
